// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the 16 controller states in the usual 1149.1 encoding,
// the default opcodes and the pattern that Capture-IR loads.
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TAP_EX2_DR   = 4'h0,
      TAP_EX1_DR   = 4'h1,
      TAP_SHIFT_DR = 4'h2,
      TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4,
      TAP_UPD_DR   = 4'h5,
      TAP_CAP_DR   = 4'h6,
      TAP_SEL_DR   = 4'h7,
      TAP_EX2_IR   = 4'h8,
      TAP_EX1_IR   = 4'h9,
      TAP_SHIFT_IR = 4'hA,
      TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC,
      TAP_UPD_IR   = 4'hD,
      TAP_CAP_IR   = 4'hE,
      TAP_TLR      = 4'hF
   } tap_state_t;

   localparam logic [3:0]  OPC_IDCODE     = 4'h2;
   localparam logic [3:0]  OPC_DEBUG      = 4'h8;
   localparam logic [3:0]  OPC_BYPASS     = 4'hF;
   localparam logic [3:0]  IR_CAPTURE     = 4'b0101;
   localparam logic [31:0] IDCODE_DEFAULT = 32'h149511C3;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register plus its next-state function; the register
// only moves on a detected TCK rise.
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       advance,
   input  logic       tms,
   output logic [3:0] state
);

   tap_state_t cur_state;
   tap_state_t next_state;

   always_ff @(posedge clock) begin
      if (!reset_n)
         cur_state <= TAP_TLR;
      else if (advance)
         cur_state <= next_state;
   end

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         TAP_TLR:      next_state = tms ? TAP_TLR    : TAP_RTI;
         TAP_RTI:      next_state = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR:   next_state = tms ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR:   next_state = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: next_state = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
         TAP_EX1_DR:   next_state = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR: next_state = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
         TAP_EX2_DR:   next_state = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
         TAP_UPD_DR:   next_state = tms ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR:   next_state = tms ? TAP_TLR    : TAP_CAP_IR;
         TAP_CAP_IR:   next_state = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: next_state = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
         TAP_EX1_IR:   next_state = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR: next_state = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
         TAP_EX2_IR:   next_state = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
         TAP_UPD_IR:   next_state = tms ? TAP_SEL_DR : TAP_RTI;
         default:      next_state = TAP_TLR;
      endcase
   end

   assign state = cur_state;

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP that oversamples tck/tms/tdi in the system clock domain, so the
// debug unit sees single-cycle capture/shift/update strobes instead of a tck clock.
module jtag_tap_sampled
   import jtag_tap_pkg::*;
#(
   parameter int                  IR_WIDTH     = 4,
   parameter logic [31:0]         IDCODE_VALUE = IDCODE_DEFAULT,
   parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(OPC_IDCODE),
   parameter logic [IR_WIDTH-1:0] INSTR_DEBUG  = IR_WIDTH'(OPC_DEBUG),
   parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = IR_WIDTH'(OPC_BYPASS),
   parameter int                  SYNC_STAGES  = 2
)(
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic tck_pad_i,
   input  logic tms_pad_i,
   input  logic tdi_pad_i,
   output logic tdo_pad_o,
   output logic tdo_oe_o,
   output logic debug_select_o,
   output logic capture_dr_o,
   output logic shift_dr_o,
   output logic update_dr_o,
   output logic tdi_o,
   input  logic debug_tdo_i,
   output logic tlr_o
);

   logic [SYNC_STAGES-1:0] tck_sync;
   logic [SYNC_STAGES-1:0] tms_sync;
   logic [SYNC_STAGES-1:0] tdi_sync;
   logic                   tck_prev;
   logic                   tck_s;
   logic                   tms_s;
   logic                   tdi_s;
   logic                   tck_rise;
   logic                   tck_fall;
   logic [IR_WIDTH-1:0]    ir;
   logic [IR_WIDTH-1:0]    ir_shift;
   logic [31:0]            id_shift;
   logic                   bypass_reg;
   logic                   sel_idcode;
   logic                   sel_bypass;
   logic                   dr_bit;
   logic [3:0]             fsm_state;
   tap_state_t             state;

   assign tck_s = tck_sync[SYNC_STAGES-1];
   assign tms_s = tms_sync[SYNC_STAGES-1];
   assign tdi_s = tdi_sync[SYNC_STAGES-1];

   // Gating with reset drops any edge that lands in a reset cycle.
   assign tck_rise = wb_rst_ni &  tck_s & ~tck_prev;
   assign tck_fall = wb_rst_ni & ~tck_s &  tck_prev;

   jtag_tap_fsm u_fsm (
      .clock   (wb_clk_i),
      .reset_n (wb_rst_ni),
      .advance (tck_rise),
      .tms     (tms_s),
      .state   (fsm_state)
   );

   assign state = tap_state_t'(fsm_state);

   assign sel_idcode     = (ir == INSTR_IDCODE);
   assign debug_select_o = (ir == INSTR_DEBUG);
   assign sel_bypass     = (ir == INSTR_BYPASS) | ~(sel_idcode | debug_select_o);
   assign dr_bit         = debug_select_o ? debug_tdo_i :
                           sel_idcode     ? id_shift[0] : bypass_reg;

   assign tlr_o        = (state == TAP_TLR);
   assign tdi_o        = tdi_s;
   assign capture_dr_o = tck_rise & debug_select_o & (state == TAP_CAP_DR);
   assign shift_dr_o   = tck_rise & debug_select_o & (state == TAP_SHIFT_DR);
   assign update_dr_o  = tck_rise & debug_select_o & (state == TAP_UPD_DR);

   // IR is forced to IDCODE whenever the FSM sits in TLR, not only on the next
   // rise, so the five-ones escape drops DEBUG selection right away.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         tck_sync   <= '0;
         tms_sync   <= '0;
         tdi_sync   <= '0;
         tck_prev   <= 1'b0;
         ir         <= INSTR_IDCODE;
         ir_shift   <= '0;
         id_shift   <= '0;
         bypass_reg <= 1'b0;
         tdo_pad_o  <= 1'b0;
         tdo_oe_o   <= 1'b0;
      end else begin
         tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck_pad_i};
         tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms_pad_i};
         tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi_pad_i};
         tck_prev <= tck_s;

         if (state == TAP_TLR)
            ir <= INSTR_IDCODE;

         if (tck_rise) begin
            case (state)
               TAP_CAP_IR:   ir_shift <= IR_WIDTH'(IR_CAPTURE);
               TAP_SHIFT_IR: ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
               TAP_UPD_IR:   ir <= ir_shift;
               TAP_CAP_DR: begin
                  if (sel_idcode)
                     id_shift <= IDCODE_VALUE;
                  if (sel_bypass)
                     bypass_reg <= 1'b0;
               end
               TAP_SHIFT_DR: begin
                  id_shift   <= {tdi_s, id_shift[31:1]};
                  bypass_reg <= tdi_s;
               end
               default: ;
            endcase
         end

         if (tck_fall) begin
            case (state)
               TAP_SHIFT_IR: begin
                  tdo_pad_o <= ir_shift[0];
                  tdo_oe_o  <= 1'b1;
               end
               TAP_SHIFT_DR: begin
                  tdo_pad_o <= dr_bit;
                  tdo_oe_o  <= 1'b1;
               end
               default: tdo_oe_o <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Bench for jtag_tap_sampled: directed TAP walks followed by random tms/tdi,
// all compared against a table-driven TAP model kept here.
module tb_jtag_tap_sampled;

   logic wb_clk_i    = 1'b0;
   logic wb_rst_ni   = 1'b0;
   logic tck_pad_i   = 1'b0;
   logic tms_pad_i   = 1'b0;
   logic tdi_pad_i   = 1'b0;
   logic debug_tdo_i = 1'b0;
   logic tdo_pad_o, tdo_oe_o, debug_select_o;
   logic capture_dr_o, shift_dr_o, update_dr_o, tdi_o, tlr_o;

   jtag_tap_sampled dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_ni      (wb_rst_ni),
      .tck_pad_i      (tck_pad_i),
      .tms_pad_i      (tms_pad_i),
      .tdi_pad_i      (tdi_pad_i),
      .tdo_pad_o      (tdo_pad_o),
      .tdo_oe_o       (tdo_oe_o),
      .debug_select_o (debug_select_o),
      .capture_dr_o   (capture_dr_o),
      .shift_dr_o     (shift_dr_o),
      .update_dr_o    (update_dr_o),
      .tdi_o          (tdi_o),
      .debug_tdo_i    (debug_tdo_i),
      .tlr_o          (tlr_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4,
                  S_EX1DR = 5, S_PDR = 6, S_EX2DR = 7, S_UPDDR = 8, S_SELIR = 9,
                  S_CAPIR = 10, S_SHIR = 11, S_EX1IR = 12, S_PIR = 13,
                  S_EX2IR = 14, S_UPDIR = 15;

   int nxt0 [16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
                     S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
   int nxt1 [16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDDR, S_EX2DR,
                     S_UPDDR, S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPDIR, S_EX2IR,
                     S_UPDIR, S_SELDR};

   int errors = 0;
   int checks = 0;
   int cap_cnt = 0, shf_cnt = 0, upd_cnt = 0;
   int exp_cap = 0, exp_shf = 0, exp_upd = 0;

   int          st;
   int          m_ir;
   int          m_irsh;
   logic [31:0] m_id;
   logic        m_byp, m_tdo, m_oe;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge wb_clk_i) begin
      if (capture_dr_o === 1'b1) cap_cnt++;
      if (update_dr_o === 1'b1) upd_cnt++;
      if (shift_dr_o === 1'b1) begin
         shf_cnt++;
         checkOutput("tdi_o", 32'(tdi_o), 32'(tdi_pad_i));
      end
   end

   task automatic modelReset();
      st     = S_TLR;
      m_ir   = 2;
      m_irsh = 0;
      m_id   = 32'h0;
      m_byp  = 1'b0;
      m_tdo  = 1'b0;
      m_oe   = 1'b0;
   endtask

   task automatic modelRise(input logic tms, input logic tdi);
      if (m_ir == 8) begin
         if (st == S_CAPDR) exp_cap++;
         if (st == S_SHDR)  exp_shf++;
         if (st == S_UPDDR) exp_upd++;
      end
      case (st)
         S_CAPIR: m_irsh = 5;
         S_SHIR:  m_irsh = (m_irsh >> 1) + (tdi ? 8 : 0);
         S_UPDIR: m_ir = m_irsh;
         S_CAPDR: begin
            if (m_ir == 2)      m_id = 32'h149511C3;
            else if (m_ir != 8) m_byp = 1'b0;
         end
         S_SHDR: begin
            m_id  = (m_id >> 1) | (tdi ? 32'h8000_0000 : 32'h0);
            m_byp = tdi;
         end
         S_TLR:   m_ir = 2;
         default: ;
      endcase
      st = tms ? nxt1[st] : nxt0[st];
      if (st == S_TLR) m_ir = 2;
   endtask

   task automatic modelFall(input logic dbg);
      if (st == S_SHIR) begin
         m_tdo = m_irsh[0];
         m_oe  = 1'b1;
      end else if (st == S_SHDR) begin
         m_tdo = (m_ir == 2) ? m_id[0] : (m_ir == 8) ? dbg : m_byp;
         m_oe  = 1'b1;
      end else begin
         m_oe = 1'b0;
      end
   endtask

   task automatic compareState();
      checkOutput("tdo", 32'(tdo_pad_o), 32'(m_tdo));
      checkOutput("tdo_oe", 32'(tdo_oe_o), 32'(m_oe));
      checkOutput("tlr", 32'(tlr_o), 32'(st == S_TLR));
      checkOutput("debug_select", 32'(debug_select_o), 32'(m_ir == 8));
      checkOutput("capture_cnt", cap_cnt, exp_cap);
      checkOutput("shift_cnt", shf_cnt, exp_shf);
      checkOutput("update_cnt", upd_cnt, exp_upd);
   endtask

   // One full TCK period: pins settle while tck is low, then 6-cycle high and low phases.
   task automatic applyStimulus(input logic tms, input logic tdi, input logic dbg);
      tms_pad_i   = tms;
      tdi_pad_i   = tdi;
      debug_tdo_i = dbg;
      repeat (3) @(negedge wb_clk_i);
      tck_pad_i = 1'b1;
      modelRise(tms, tdi);
      repeat (6) @(negedge wb_clk_i);
      tck_pad_i = 1'b0;
      modelFall(dbg);
      repeat (6) @(negedge wb_clk_i);
      compareState();
   endtask

   task automatic doReset(input logic tck_level);
      tck_pad_i = tck_level;
      wb_rst_ni = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      tck_pad_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      modelReset();
      repeat (2) @(negedge wb_clk_i);
      compareState();
   endtask

   task automatic goReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   task automatic goShiftDr();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic shiftDr(input int n, input logic [31:0] din, input logic [31:0] dbg,
                          output logic [31:0] dout);
      dout = 32'h0;
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo_pad_o;
         applyStimulus(i == n - 1, din[i], dbg[i]);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic loadIr(input logic [3:0] value, output logic [3:0] dout);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         dout[i] = tdo_pad_o;
         applyStimulus(i == 3, value[i], 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  ir_rd;
      int          c0, s0, u0;

      modelReset();
      wb_rst_ni = 1'b0;
      repeat (5) @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      compareState();

      $display("[TB] IDCODE read after reset");
      goReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      shiftDr(32, 32'h0, 32'h0, rd);
      checkOutput("idcode", rd, 32'h149511C3);

      $display("[TB] IR load of DEBUG");
      loadIr(4'h8, ir_rd);
      checkOutput("ir_capture", 32'(ir_rd), 32'h5);
      checkOutput("debug_sel_after_upd", 32'(debug_select_o), 32'h1);

      $display("[TB] DEBUG DR walk");
      c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
      goShiftDr();
      shiftDr(3, 32'h6, 32'h5, rd);
      checkOutput("capture_pulses", cap_cnt - c0, 1);
      checkOutput("shift_pulses", shf_cnt - s0, 3);
      checkOutput("update_pulses", upd_cnt - u0, 1);

      $display("[TB] five-ones escape from Shift-DR");
      goShiftDr();
      goReset();
      checkOutput("escape_tlr", 32'(tlr_o), 32'h1);
      checkOutput("escape_ir_idcode", 32'(debug_select_o), 32'h0);

      $display("[TB] BYPASS delay");
      applyStimulus(1'b0, 1'b0, 1'b0);
      loadIr(4'hF, ir_rd);
      goShiftDr();
      shiftDr(9, 32'h0A5, 32'h0, rd);
      checkOutput("bypass_delay", rd, 32'h14A);

      $display("[TB] reset during IDCODE shift");
      goReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'(i), 1'b0);
      tms_pad_i = 1'b0;
      tdi_pad_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      u0 = upd_cnt;
      doReset(1'b1);
      checkOutput("rst_tdo", 32'(tdo_pad_o), 32'h0);
      checkOutput("rst_oe", 32'(tdo_oe_o), 32'h0);
      checkOutput("rst_tlr", 32'(tlr_o), 32'h1);
      checkOutput("rst_no_update", upd_cnt - u0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      shiftDr(32, 32'h0, 32'h0, rd);
      checkOutput("idcode_after_rst", rd, 32'h149511C3);

      $display("[TB] random tms/tdi walk");
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 59) == 0)
            doReset(1'($urandom_range(0, 1)));
         else
            applyStimulus($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtag_tap_sampled.md
Name: jtag_tap_sampled

Overview:
JTAG TAP responder for the far end of the JTAG pads (tck/tms/tdi in, tdo out).
- Oversamples the pad signals in the single system clock domain and runs the IEEE 1149.1 16-state TAP FSM.
- Provides IDCODE and BYPASS data registers.
- Exports a DEBUG data-register select plus capture/shift/update strobes to the debug unit.
- Sits between the top-level JTAG pads and the debug interface, so JTAG access needs no separate tck clock domain.

Parameters:
IR_WIDTH, 4, instruction register width
IDCODE_VALUE, 32'h149511C3, value captured by IDCODE
INSTR_IDCODE, 4'h2, IDCODE opcode
INSTR_DEBUG, 4'h8, DEBUG opcode
INSTR_BYPASS, 4'hF, BYPASS opcode; all undefined opcodes also select BYPASS
SYNC_STAGES, 2, pad synchronizer depth (minimum 2)

Ports:
wb_clk_i  in  1  system clock; the only clock
wb_rst_ni  in  1  reset, synchronous, active-low
tck_pad_i  in  1  JTAG TCK, asynchronous to wb_clk_i
tms_pad_i  in  1  JTAG TMS
tdi_pad_i  in  1  JTAG TDI
tdo_pad_o  out  1  JTAG TDO
tdo_oe_o  out  1  TDO output enable
debug_select_o  out  1  IR holds INSTR_DEBUG
capture_dr_o  out  1  one-cycle strobe: TCK rise while in Capture-DR
shift_dr_o  out  1  one-cycle strobe: TCK rise while in Shift-DR
update_dr_o  out  1  one-cycle strobe: TCK rise while in Update-DR
tdi_o  out  1  synchronized TDI, valid with shift_dr_o
debug_tdo_i  in  1  serial output of the debug DR
tlr_o  out  1  FSM in Test-Logic-Reset

Behaviour:
Pad synchronization
- tck, tms, tdi each pass through SYNC_STAGES flops.
- One extra tck flop gives edge detect: rise = synced & ~prev; fall = ~synced & prev.
- Pad latency to edge detection is SYNC_STAGES+1 cycles.
- Legal TCK timing: high and low phases each ≥ SYNC_STAGES+2 wb_clk_i cycles. Faster TCK is undefined and not checked.

On each TCK rise (single-cycle event)
- FSM moves per tms on the standard 1149.1 graph: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Actions are taken for the state held before the transition:
  - CapIR: ir_shift <= 4'b0101 (LSBs 01 per standard).
  - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR: ir <= ir_shift.
  - CapDR: if IDCODE, id_shift <= IDCODE_VALUE; if BYPASS, bypass_reg <= 0.
  - ShDR: id_shift shifts right with tdi entering at the MSB; bypass_reg <= tdi.
  - TLR: ir <= INSTR_IDCODE.
- capture_dr_o, shift_dr_o and update_dr_o pulse for exactly one wb_clk_i cycle, coincident with that rise, only when debug_select_o = 1.

On each TCK fall
- In ShIR: tdo_pad_o <= ir_shift[0], tdo_oe_o <= 1.
- In ShDR: tdo_pad_o <= selected DR bit 0 (id_shift[0], bypass_reg, or debug_tdo_i), tdo_oe_o <= 1.
- In all other states: tdo_oe_o <= 0 and tdo_pad_o holds.

Other rules
- Five TCK rises with tms = 1 reach TLR from any state.
- tlr_o and debug_select_o are combinational from registered state/IR.
- Reset (wb_rst_ni = 0 on a clock edge) forces:
  - state TLR, ir INSTR_IDCODE, ir_shift 0, id_shift 0, bypass_reg 0;
  - tdo_pad_o 0, tdo_oe_o 0, all strobes 0, all synchronizer flops 0.
- Reset mid-shift aborts the shift with no update strobe.
- A TCK edge detected in the same cycle as reset is discarded.
- Rise and fall cannot coincide, because edge detection uses a single synchronized signal.

Decomposition:
- Package jtag_tap_pkg holds:
  - the TAP state enum (4-bit encoding, TLR = 4'hF);
  - opcode constants;
  - the IR capture pattern.
- Sub-module jtag_tap_fsm holds the pure next-state function plus the state register, advanced by the rise enable.
- Synchronizers, shift registers and TDO logic stay in the top.

Test Plan:
- Reset, then tms 1,1,1,1,1 and 0,1,0,0, then 32 shift cycles -> TDO yields 32'h149511C3 LSB-first; tdo_oe_o is high only during the shifts.
- From ShDR, five rises with tms = 1 -> tlr_o = 1; ir = INSTR_IDCODE.
- Load IR 4'hF; in ShDR shift 8'hA5 followed by 1 zero -> TDO returns 0 then A5 bits, i.e. a 1-bit delay.
- Shift IR with tdi 4'h8 -> TDO during ShIR shows 1,0,1,0, i.e. the capture 0101 read LSB-first; debug_select_o = 1 after UpdIR.
- DEBUG selected, walk CapDR, 3×ShDR, UpdDR -> exactly 1 capture_dr_o, 3 shift_dr_o and 1 update_dr_o pulse, each one cycle wide; TDO follows debug_tdo_i.
- Assert wb_rst_ni low during the 10th IDCODE shift -> all outputs reset next edge; no update_dr_o; a subsequent read returns the IDCODE intact.
